// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and types for the 1:4 stream demultiplexer
package stream_demux_pkg;
  localparam int N_CH      = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W_DEF = 8;

  typedef logic [SEL_W-1:0] chan_idx_t;
endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slot with push counter
module demux_slot #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             rd_ready,
  output logic             valid,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A push wins over a pop in the same cycle, so a draining slot refills without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rdata <= '0;
      cnt   <= '0;
    end else if (push) begin
      valid <= 1'b1;
      rdata <= wdata;
      cnt   <= cnt + CNT_ONE;
    end else if (valid && rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// rtl/stream_demux_1_4.sv - valid/ready 1:4 stream demultiplexer with per-channel accept counters
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [W-1:0]                in_data,
  input  chan_idx_t                   in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_CH-1:0][W-1:0]      out_data,
  output logic [N_CH-1:0]             out_valid,
  input  logic [N_CH-1:0]             out_ready,
  output logic [N_CH-1:0][CNT_W-1:0]  acc_cnt
);

  logic            in_fire;
  logic [N_CH-1:0] push;

  // Only the addressed slot gates the input; other channels' backpressure is irrelevant.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    push = '0;
    for (int k = 0; k < N_CH; k++) begin
      push[k] = in_fire && (in_sel == chan_idx_t'(k));
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[k]),
      .wdata    (in_data),
      .rd_ready (out_ready[k]),
      .valid    (out_valid[k]),
      .rdata    (out_data[k]),
      .cnt      (acc_cnt[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb/tb_stream_demux_1_4.sv - self-checking scoreboard bench for stream_demux_1_4
module tb_stream_demux_1_4;

  logic                 clk;
  logic                 rst_n;
  logic [3:0]           in_data;
  logic [1:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][3:0]      out_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [3:0][7:0]      acc_cnt;

  int n_checks;
  int n_fail;

  logic [3:0] exp_q[4][$];
  logic [3:0] got_q[4][$];
  logic [7:0] exp_cnt[4];

  stream_demux_1_4 #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_cnt   (acc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record accepted words and consumed words at the falling edge, then realign to posedge+1.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      if (out_valid[k] && out_ready[k]) got_q[k].push_back(out_data[k]);
    if (in_valid && in_ready) begin
      exp_q[in_sel].push_back(in_data);
      exp_cnt[in_sel] = exp_cnt[in_sel] + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [3:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 4'h0 || out_data !== 16'h0 || acc_cnt !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%h data=%h cnt=%h rdy=%b, need 0/0/0/1", out_valid, out_data, acc_cnt, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 4'(4'hA + i));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_ready%0d: got %b need 1", i, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid[i] !== 1'b1 || out_data[i] !== 4'(4'hA + i)) begin
        n_fail++;
        $display("FAIL basic_latency%0d: valid=%b data=%h need 1/%h", i, out_valid[i], out_data[i], 4'(4'hA + i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (acc_cnt !== {8'd1, 8'd1, 8'd1, 8'd1} || out_valid !== 4'h0) begin
      n_fail++;
      $display("FAIL basic_cnt: cnt=%h valid=%h need 01010101/0", acc_cnt, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      while (got_q[k].size() > 0 && exp_q[k].size() > 0) begin
        logic [3:0] g, e;
        g = got_q[k].pop_front();
        e = exp_q[k].pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL basic_sb_ch%0d: got %h need %h", k, g, e); end
      end
      n_checks++;
      if (got_q[k].size() != 0 || exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL basic_sb_left_ch%0d: got %0d exp %0d left", k, got_q[k].size(), exp_q[k].size());
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 4'b1011;
    send(2'd2, 4'h5);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready: got %b need 1", in_ready); end
    tick();
    in_data = 4'h6;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid[2] !== 1'b1 || out_data[2] !== 4'h5) begin
        n_fail++;
        $display("FAIL stall_hold%0d: rdy=%b valid=%b data=%h need 0/1/5", c, in_ready, out_valid[2], out_data[2]);
      end
      tick();
    end
    out_ready[2] = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b need 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== 4'h6) begin
      n_fail++;
      $display("FAIL stall_second: valid=%b data=%h need 1/6", out_valid[2], out_data[2]);
    end
    tick();
    n_checks++;
    if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL stall_drained: valid=%b need 0", out_valid[2]); end
    for (int k = 0; k < 4; k++) begin
      while (got_q[k].size() > 0 && exp_q[k].size() > 0) begin
        logic [3:0] g, e;
        g = got_q[k].pop_front();
        e = exp_q[k].pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL stall_sb_ch%0d: got %h need %h", k, g, e); end
      end
      n_checks++;
      if (got_q[k].size() != 0 || exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL stall_sb_left_ch%0d: got %0d exp %0d left", k, got_q[k].size(), exp_q[k].size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] start;
    start = acc_cnt[1];
    out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      send(2'd1, 4'(i));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b need 1", i, in_ready); end
      tick();
      n_checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 4'(i)) begin
        n_fail++;
        $display("FAIL b2b_word%0d: valid=%b data=%h need 1/%h", i, out_valid[1], out_data[1], 4'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (acc_cnt[1] !== 8'(start + 8'd8) || acc_cnt[1] !== exp_cnt[1]) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d need %0d", acc_cnt[1], 8'(start + 8'd8));
    end
    for (int k = 0; k < 4; k++) begin
      while (got_q[k].size() > 0 && exp_q[k].size() > 0) begin
        logic [3:0] g, e;
        g = got_q[k].pop_front();
        e = exp_q[k].pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL b2b_sb_ch%0d: got %h need %h", k, g, e); end
      end
      n_checks++;
      if (got_q[k].size() != 0 || exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL b2b_sb_left_ch%0d: got %0d exp %0d left", k, got_q[k].size(), exp_q[k].size());
      end
    end
  endtask

  task automatic test_hol();
    logic [7:0] cnt3;
    cnt3 = acc_cnt[3];
    out_ready = 4'b1110;
    send(2'd0, 4'h1);
    tick();
    send(2'd0, 4'h2);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid[3] !== 1'b0 || acc_cnt[3] !== cnt3 || out_data[0] !== 4'h1) begin
        n_fail++;
        $display("FAIL hol_block%0d: rdy=%b v3=%b cnt3=%0d d0=%h need 0/0/%0d/1", c, in_ready, out_valid[3], acc_cnt[3], out_data[0], cnt3);
      end
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    send(2'd3, 4'h3);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hol_ch3_ready: got %b need 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid[3] !== 1'b1 || out_data[3] !== 4'h3 || acc_cnt[3] !== 8'(cnt3 + 8'd1)) begin
      n_fail++;
      $display("FAIL hol_ch3_word: valid=%b data=%h cnt=%0d need 1/3/%0d", out_valid[3], out_data[3], acc_cnt[3], 8'(cnt3 + 8'd1));
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      while (got_q[k].size() > 0 && exp_q[k].size() > 0) begin
        logic [3:0] g, e;
        g = got_q[k].pop_front();
        e = exp_q[k].pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL hol_sb_ch%0d: got %h need %h", k, g, e); end
      end
      n_checks++;
      if (got_q[k].size() != 0 || exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL hol_sb_left_ch%0d: got %0d exp %0d left", k, got_q[k].size(), exp_q[k].size());
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] c0, c1, c2, c3;
    c0 = acc_cnt[0];
    c1 = acc_cnt[1];
    c2 = acc_cnt[2];
    c3 = acc_cnt[3];
    out_ready = 4'hF;
    for (int i = 0; i < 256; i++) begin
      send(2'd3, 4'(i));
      tick();
      if (8'(c3 + 8'(i + 1)) == 8'd0) begin
        n_checks++;
        if (acc_cnt[3] !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d need 0", acc_cnt[3]); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (acc_cnt[3] !== c3 || acc_cnt[3] !== exp_cnt[3]) begin
      n_fail++;
      $display("FAIL wrap_cnt3: got %0d need %0d", acc_cnt[3], c3);
    end
    n_checks++;
    if (acc_cnt[0] !== c0 || acc_cnt[1] !== c1 || acc_cnt[2] !== c2) begin
      n_fail++;
      $display("FAIL wrap_others: got %0d/%0d/%0d need %0d/%0d/%0d", acc_cnt[0], acc_cnt[1], acc_cnt[2], c0, c1, c2);
    end
    for (int k = 0; k < 4; k++) begin
      while (got_q[k].size() > 0 && exp_q[k].size() > 0) begin
        logic [3:0] g, e;
        g = got_q[k].pop_front();
        e = exp_q[k].pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL wrap_sb_ch%0d: got %h need %h", k, g, e); end
      end
      n_checks++;
      if (got_q[k].size() != 0 || exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL wrap_sb_left_ch%0d: got %0d exp %0d left", k, got_q[k].size(), exp_q[k].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), 4'(9 + k));
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'hF || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_full: valid=%h rdy=%b need F/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 4'h0 || out_data !== 16'h0 || acc_cnt !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%h data=%h cnt=%h rdy=%b need 0/0/0/1", out_valid, out_data, acc_cnt, in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      got_q[k].delete();
      exp_cnt[k] = 8'd0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 4'h0 || acc_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_after: valid=%h cnt=%h need 0/0", out_valid, acc_cnt);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_data   = 4'h0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_hol();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
